// File: rtl/sprite_pos_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pos_ctrl
// Purpose  : Sprite X/Y position registers at I/O addresses 120 (X) and
//            121 (Y). A CPU store either snaps an axis straight to the
//            clamped coordinate or sets a target that the sprite glides
//            toward by up to STEP pixels per frame tick.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            we                   - CPU memory-write strobe
//            sprite_enbX/Y        - decoder selects for the X / Y registers
//            wd[31:0]             - write data; bit31 = snap, [30:0] = coord
//            frame_tick           - one-cycle pulse per frame
//            pos_x/pos_y[9:0]     - current sprite top-left corner
//            tgt_x/tgt_y[9:0]     - committed glide targets
//            moving               - position differs from target on an axis
// Revision : 1.0 - initial release
// ============================================================================
module sprite_pos_ctrl #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int STEP     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        sprite_enbX,
    input  logic        sprite_enbY,
    input  logic [31:0] wd,
    input  logic        frame_tick,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [9:0]  tgt_x,
    output logic [9:0]  tgt_y,
    output logic        moving
);

    localparam logic [30:0] c_max_x   = 31'(SCREEN_W - SPRITE_W);
    localparam logic [30:0] c_max_y   = 31'(SCREEN_H - SPRITE_H);
    localparam logic [9:0]  c_step    = 10'(STEP);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_MOVING = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [9:0]  r_pos_x, r_pos_y, r_tgt_x, r_tgt_y;
    logic [9:0]  w_pos_x_next, w_pos_y_next, w_tgt_x_next, w_tgt_y_next;
    logic [9:0]  w_clamp_x, w_clamp_y;
    logic        w_commit_x, w_commit_y, w_snap;

    // One glide step from pos toward tgt, limited so it never overshoots.
    function automatic logic [9:0] f_step(input logic [9:0] pos,
                                          input logic [9:0] tgt);
        logic [9:0] diff;
        logic [9:0] res;
        res = pos;
        if (pos < tgt) begin
            diff = tgt - pos;
            res  = pos + ((diff < c_step) ? diff : c_step);
        end else if (pos > tgt) begin
            diff = pos - tgt;
            res  = pos - ((diff < c_step) ? diff : c_step);
        end
        return res;
    endfunction

    assign w_commit_x = we & sprite_enbX;
    assign w_commit_y = we & sprite_enbY;
    assign w_snap     = wd[31];

    // Full 31-bit compare so huge values clamp instead of wrapping.
    assign w_clamp_x = (wd[30:0] > c_max_x) ? c_max_x[9:0] : wd[9:0];
    assign w_clamp_y = (wd[30:0] > c_max_y) ? c_max_y[9:0] : wd[9:0];

    // Next-state datapath and FSM. A snap overrides a coincident tick; a
    // glide commit on a tick steps against the old target.
    always_comb begin
        w_pos_x_next = r_pos_x;
        w_pos_y_next = r_pos_y;
        w_tgt_x_next = r_tgt_x;
        w_tgt_y_next = r_tgt_y;
        w_state_next = r_state;

        if (frame_tick && (r_state == ST_MOVING)) begin
            w_pos_x_next = f_step(r_pos_x, r_tgt_x);
            w_pos_y_next = f_step(r_pos_y, r_tgt_y);
        end

        if (w_commit_x) begin
            w_tgt_x_next = w_clamp_x;
            if (w_snap) begin
                w_pos_x_next = w_clamp_x;
            end
        end
        if (w_commit_y) begin
            w_tgt_y_next = w_clamp_y;
            if (w_snap) begin
                w_pos_y_next = w_clamp_y;
            end
        end

        if ((w_tgt_x_next != w_pos_x_next) || (w_tgt_y_next != w_pos_y_next)) begin
            w_state_next = ST_MOVING;
        end else begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos_x <= 10'd0;
            r_pos_y <= 10'd0;
            r_tgt_x <= 10'd0;
            r_tgt_y <= 10'd0;
            r_state <= ST_IDLE;
        end else begin
            r_pos_x <= w_pos_x_next;
            r_pos_y <= w_pos_y_next;
            r_tgt_x <= w_tgt_x_next;
            r_tgt_y <= w_tgt_y_next;
            r_state <= w_state_next;
        end
    end

    assign pos_x  = r_pos_x;
    assign pos_y  = r_pos_y;
    assign tgt_x  = r_tgt_x;
    assign tgt_y  = r_tgt_y;
    assign moving = (r_state == ST_MOVING);

endmodule
`default_nettype wire

// File: tb/tb_sprite_pos_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_pos_ctrl
// Purpose  : Directed self-checking bench for sprite_pos_ctrl with
//            hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_pos_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic        sprite_enbX = 1'b0;
    logic        sprite_enbY = 1'b0;
    logic [31:0] wd = 32'd0;
    logic        frame_tick = 1'b0;
    logic [9:0]  pos_x, pos_y, tgt_x, tgt_y;
    logic        moving;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sprite_pos_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .sprite_enbX (sprite_enbX),
        .sprite_enbY (sprite_enbY),
        .wd          (wd),
        .frame_tick  (frame_tick),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .tgt_x       (tgt_x),
        .tgt_y       (tgt_y),
        .moving      (moving)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Apply one cycle of inputs, then return #1 after the edge.
    task automatic cyc(input logic w, input logic ex, input logic ey,
                       input logic [31:0] d, input logic t);
        we = w; sprite_enbX = ex; sprite_enbY = ey; wd = d; frame_tick = t;
        @(posedge clk);
        #1;
        we = 1'b0; sprite_enbX = 1'b0; sprite_enbY = 1'b0; wd = 32'd0; frame_tick = 1'b0;
    endtask

    task automatic tick();
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic chk_all(input string tag, input logic [9:0] px, input logic [9:0] py,
                           input logic [9:0] tx, input logic [9:0] ty, input logic mv);
        chk({tag, ".pos_x"}, 32'(pos_x), 32'(px));
        chk({tag, ".pos_y"}, 32'(pos_y), 32'(py));
        chk({tag, ".tgt_x"}, 32'(tgt_x), 32'(tx));
        chk({tag, ".tgt_y"}, 32'(tgt_y), 32'(ty));
        chk({tag, ".moving"}, 32'(moving), 32'(mv));
    endtask

    initial begin
        // Reset for two cycles
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk_all("reset", 10'd0, 10'd0, 10'd0, 10'd0, 1'b0);
        tick(); tick();
        chk_all("idle_tick", 10'd0, 10'd0, 10'd0, 10'd0, 1'b0);

        // Glide X to 10
        cyc(1'b1, 1'b1, 1'b0, 32'd10, 1'b0);
        chk_all("glide_wr", 10'd0, 10'd0, 10'd10, 10'd0, 1'b1);
        tick(); chk("glide_t1", 32'(pos_x), 32'd4);
        tick(); chk("glide_t2", 32'(pos_x), 32'd8);
        chk("glide_t2_mv", 32'(moving), 32'd1);
        tick(); chk_all("glide_t3", 10'd10, 10'd0, 10'd10, 10'd0, 1'b0);
        tick(); chk("glide_t4", 32'(pos_x), 32'd10);

        // Snap Y with clamp (1000 -> 448)
        cyc(1'b1, 1'b0, 1'b1, 32'h8000_03E8, 1'b0);
        chk_all("snap_y", 10'd10, 10'd448, 10'd10, 10'd448, 1'b0);

        // Clamp X: snap to 600, then glide to 0x7FFFFFFF -> 608
        cyc(1'b1, 1'b1, 1'b0, 32'h8000_0258, 1'b0);
        chk("snap600", 32'(pos_x), 32'd600);
        cyc(1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0);
        chk("clamp_tgt", 32'(tgt_x), 32'd608);
        chk("clamp_mv", 32'(moving), 32'd1);
        tick(); chk("clamp_t1", 32'(pos_x), 32'd604);
        tick(); chk("clamp_t2", 32'(pos_x), 32'd608);
        chk("clamp_t2_mv", 32'(moving), 32'd0);

        // Tick/write collision
        cyc(1'b1, 1'b1, 1'b0, 32'h8000_0014, 1'b0);
        chk_all("snap20", 10'd20, 10'd448, 10'd20, 10'd448, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        chk_all("coll_glide", 10'd20, 10'd448, 10'd0, 10'd448, 1'b1);
        tick(); chk("coll_next", 32'(pos_x), 32'd16);
        cyc(1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b1);
        chk_all("coll_snap", 10'd0, 10'd448, 10'd0, 10'd448, 1'b0);

        // Both axes committed in one write
        cyc(1'b1, 1'b1, 1'b1, 32'd8, 1'b0);
        chk_all("both_wr", 10'd0, 10'd448, 10'd8, 10'd8, 1'b1);
        tick(); chk_all("both_t1", 10'd4, 10'd444, 10'd8, 10'd8, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 32'h8000_0008, 1'b0);
        tick(); chk_all("both_t2", 10'd8, 10'd8, 10'd8, 10'd8, 1'b0);

        // Mid-motion reset during glide 0 -> 100
        cyc(1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'd100, 1'b0);
        tick(); tick(); tick();
        chk_all("mid_glide", 10'd12, 10'd0, 10'd100, 10'd0, 1'b1);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 32'h8000_0050, 1'b1);
        rst = 1'b0;
        chk_all("mid_reset", 10'd0, 10'd0, 10'd0, 10'd0, 1'b0);

        // Ignored writes: no enables, or we low
        cyc(1'b1, 1'b0, 1'b0, 32'd50, 1'b0);
        chk_all("no_enb", 10'd0, 10'd0, 10'd0, 10'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h8000_0032, 1'b0);
        chk_all("we_low", 10'd0, 10'd0, 10'd0, 10'd0, 1'b0);
        tick();
        chk_all("ign_tick", 10'd0, 10'd0, 10'd0, 10'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
